// File: rtl/arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_pkg: shared types and constants for the unified memory port arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ         = 2;
    localparam int MAX_MEM_LATENCY = 7;
    localparam int CNT_W           = 3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_select: combinational 2-way round-robin pick (one-hot grant + index).
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_select
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               idx_o
);

    always_comb begin
        idx_o = 1'b0;
        gnt_o = '0;
        // On a tie the requester that did not win last time goes first.
        if (req_i[0] && req_i[1]) begin
            idx_o = ~last_i;
        end else if (req_i[1]) begin
            idx_o = 1'b1;
        end
        if (|req_i) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter: round-robin arbiter for the core's single unified memory port,
// tracking fixed-latency reads back to their owner. Revision: 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MEM_LATENCY = 1     // legal range 1..MAX_MEM_LATENCY
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             owner_q, owner_d;
    logic             last_q,  last_d;

    logic [NUM_REQ-1:0] w_sel_gnt;
    logic               w_sel_idx;
    logic               w_win_we;

    rr_select u_rr_select (
        .req_i  ({req1, req0}),
        .last_i (last_q),
        .gnt_o  (w_sel_gnt),
        .idx_o  (w_sel_idx)
    );

    assign w_win_we = w_sel_idx ? we1 : we0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        // Grants are combinational from req, so hold every output quiet in reset.
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt0      = w_sel_gnt[0];
                        gnt1      = w_sel_gnt[1];
                        mem_en    = 1'b1;
                        mem_we    = w_win_we;
                        mem_adr   = w_sel_idx ? adr1   : adr0;
                        mem_wdata = w_sel_idx ? wdata1 : wdata0;
                        last_d    = w_sel_idx;
                        if (!w_win_we) begin
                            owner_d = w_sel_idx;
                            cnt_d   = LAT_M1;
                            state_d = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                        if (owner_q) begin
                            rvalid1 = 1'b1;
                            rdata1  = mem_rdata;
                        end else begin
                            rvalid0 = 1'b1;
                            rdata0  = mem_rdata;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter: directed bench for two arbiter instances (latency 1 and 3).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct {
        int          who;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    int          cyc;
    int          tests;
    int          fails;
    exp_t        sbq [2][$];
    logic        pend0 [2];
    logic        pend1 [2];

    logic        req0 [2], req1 [2], we0 [2], we1 [2];
    logic [31:0] adr0 [2], adr1 [2], wdata0 [2], wdata1 [2];
    logic        gnt0 [2], gnt1 [2], rvalid0 [2], rvalid1 [2];
    logic [31:0] rdata0 [2], rdata1 [2];
    logic        mem_en [2], mem_we [2];
    logic [31:0] mem_adr [2], mem_wdata [2], mem_rdata [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : 3;
        logic [31:0] mem  [256];
        logic [31:0] pipe [L];

        mem_arbiter #(.WIDTH(32), .MEM_LATENCY(L)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req0      (req0[k]),
            .req1      (req1[k]),
            .we0       (we0[k]),
            .we1       (we1[k]),
            .adr0      (adr0[k]),
            .adr1      (adr1[k]),
            .wdata0    (wdata0[k]),
            .wdata1    (wdata1[k]),
            .gnt0      (gnt0[k]),
            .gnt1      (gnt1[k]),
            .rvalid0   (rvalid0[k]),
            .rvalid1   (rvalid1[k]),
            .rdata0    (rdata0[k]),
            .rdata1    (rdata1[k]),
            .mem_en    (mem_en[k]),
            .mem_we    (mem_we[k]),
            .mem_adr   (mem_adr[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_rdata (mem_rdata[k])
        );

        // Synchronous memory with L-cycle read pipeline; non-read cycles
        // return a poison word so ungated rdata would be visible.
        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < 256; i++) mem[i] <= {24'hA5A5A5, i[7:0]};
                mem[8'h10] <= 32'hDEADBEEF;
                mem[8'h40] <= 32'h12345678;
                for (int j = 0; j < L; j++) pipe[j] <= 32'h0;
            end else begin
                if (mem_en[k] && mem_we[k]) mem[mem_adr[k][9:2]] <= mem_wdata[k];
                pipe[0] <= (mem_en[k] && !mem_we[k]) ? mem[mem_adr[k][9:2]] : 32'h0BAD0BAD;
                for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
            end
        end
        assign mem_rdata[k] = pipe[L-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input int k, input string tag);
        chk({tag, "_gnt0"},    32'(gnt0[k]),    32'd0);
        chk({tag, "_gnt1"},    32'(gnt1[k]),    32'd0);
        chk({tag, "_rvalid0"}, 32'(rvalid0[k]), 32'd0);
        chk({tag, "_rvalid1"}, 32'(rvalid1[k]), 32'd0);
        chk({tag, "_rdata0"},  rdata0[k],       32'd0);
        chk({tag, "_rdata1"},  rdata1[k],       32'd0);
        chk({tag, "_mem_en"},  32'(mem_en[k]),  32'd0);
        chk({tag, "_mem_we"},  32'(mem_we[k]),  32'd0);
        chk({tag, "_mem_adr"}, mem_adr[k],      32'd0);
        chk({tag, "_mem_wd"},  mem_wdata[k],    32'd0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard, mutual exclusion, rdata gating and request-hold protocol.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            chk("gnt_onehot",    32'(gnt0[k] && gnt1[k]),       32'd0);
            chk("rvalid_onehot", 32'(rvalid0[k] && rvalid1[k]), 32'd0);
            if (!rvalid0[k]) chk("rdata0_gated", rdata0[k], 32'd0);
            if (!rvalid1[k]) chk("rdata1_gated", rdata1[k], 32'd0);
            if (reset && pend0[k]) chk("req0_held", 32'(req0[k]), 32'd1);
            if (reset && pend1[k]) chk("req1_held", 32'(req1[k]), 32'd1);
            pend0[k] = reset && req0[k] && !gnt0[k];
            pend1[k] = reset && req1[k] && !gnt1[k];
            if (rvalid0[k] || rvalid1[k]) begin
                chk("rvalid_expected", 32'(sbq[k].size() != 0), 32'd1);
                if (sbq[k].size() != 0) begin
                    e = sbq[k].pop_front();
                    chk("rvalid_who",   32'(rvalid1[k]), 32'(e.who));
                    chk("rvalid_data",  rvalid1[k] ? rdata1[k] : rdata0[k], e.data);
                    chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (sbq[k].size() != 0 && cyc > sbq[k][0].cyc) begin
                e = sbq[k].pop_front();
                chk("rvalid_timeout", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int t;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req0[k] = 0; req1[k] = 0; we0[k] = 0; we1[k] = 0;
            adr0[k] = 0; adr1[k] = 0; wdata0[k] = 0; wdata1[k] = 0;
            pend0[k] = 0; pend1[k] = 0;
        end
        tick;
        tick;
        // Reset state, with a request already pending on instance 0.
        req0[0] = 1;
        @(negedge clk);
        chk_quiet(0, "rst0");
        chk_quiet(1, "rst1");

        // First read after release: gnt0 in the same cycle, data one cycle later.
        tick;
        reset = 1'b1;
        we0[0] = 0; adr0[0] = 32'h40;
        @(negedge clk);
        chk("rd_gnt0",   32'(gnt0[0]),   32'd1);
        chk("rd_gnt1",   32'(gnt1[0]),   32'd0);
        chk("rd_mem_en", 32'(mem_en[0]), 32'd1);
        chk("rd_mem_we", 32'(mem_we[0]), 32'd0);
        chk("rd_adr",    mem_adr[0],     32'h40);
        sbq[0].push_back('{0, 32'hDEADBEEF, cyc + 1});
        tick;
        req0[0] = 0;
        @(negedge clk);
        chk("rd_wait_gnt0", 32'(gnt0[0]),    32'd0);
        chk("rd_rvalid0",   32'(rvalid0[0]), 32'd1);
        chk("rd_rdata0",    rdata0[0],       32'hDEADBEEF);

        // Fresh reset so contention starts with requester 0.
        tick; reset = 1'b0;
        tick; reset = 1'b1;
        req0[0] = 1; we0[0] = 1; adr0[0] = 32'h80; wdata0[0] = 32'h11;
        req1[0] = 1; we1[0] = 1; adr1[0] = 32'h84; wdata1[0] = 32'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont_gnt0",  32'(gnt0[0]), 32'(i % 2 == 0));
            chk("cont_gnt1",  32'(gnt1[0]), 32'(i % 2 == 1));
            chk("cont_wdata", mem_wdata[0], (i % 2 == 0) ? 32'h11 : 32'h22);
            tick;
        end
        req1[0] = 0;
        for (int i = 0; i < 3; i++) begin
            adr0[0] = 32'h88 + 32'(4 * i);
            @(negedge clk);
            chk("b2b_gnt0", 32'(gnt0[0]), 32'd1);
            chk("b2b_adr",  mem_adr[0],   32'h88 + 32'(4 * i));
            tick;
        end
        req0[0] = 0;

        // Latency 3: read by requester 1 blocks requester 0 for three cycles.
        req0[1] = 1; we0[1] = 1; adr0[1] = 32'h300; wdata0[1] = 32'h55;
        @(negedge clk);
        chk("l3_pre_gnt0", 32'(gnt0[1]), 32'd1);
        tick;
        we0[1] = 0; adr0[1] = 32'h40;
        req1[1] = 1; we1[1] = 0; adr1[1] = 32'h100;
        @(negedge clk);
        chk("l3_gnt1", 32'(gnt1[1]), 32'd1);
        chk("l3_gnt0", 32'(gnt0[1]), 32'd0);
        chk("l3_adr",  mem_adr[1],   32'h100);
        t = cyc;
        sbq[1].push_back('{1, 32'h12345678, t + 3});
        tick;
        req1[1] = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("l3_wait_gnt0", 32'(gnt0[1]),   32'd0);
            chk("l3_wait_en",   32'(mem_en[1]), 32'd0);
            tick;
        end
        @(negedge clk);
        chk("l3_next_gnt0",  32'(gnt0[1]), 32'd1);
        chk("l3_next_cycle", 32'(cyc),     32'(t + 4));
        chk("l3_next_adr",   mem_adr[1],   32'h40);
        sbq[1].push_back('{0, 32'hDEADBEEF, cyc + 3});
        tick;
        req0[1] = 0;
        repeat (4) tick;

        // Reset one cycle into a latency-3 read: read is dropped, arbitration restarts.
        req1[1] = 1; we1[1] = 0; adr1[1] = 32'h100;
        @(negedge clk);
        chk("rst_rd_gnt1", 32'(gnt1[1]), 32'd1);
        tick;
        reset = 1'b0;
        req1[1] = 0;
        @(negedge clk);
        chk("rst_rd_rv_t1", 32'(rvalid1[1]), 32'd0);
        tick;
        reset = 1'b1;
        req0[1] = 1; we0[1] = 1; adr0[1] = 32'h300; wdata0[1] = 32'h66;
        req1[1] = 1; we1[1] = 1; adr1[1] = 32'h304; wdata1[1] = 32'h77;
        @(negedge clk);
        chk("rst_cont_gnt0", 32'(gnt0[1]),    32'd1);
        chk("rst_cont_gnt1", 32'(gnt1[1]),    32'd0);
        chk("rst_rd_rv_t2",  32'(rvalid1[1]), 32'd0);
        tick;
        req0[1] = 0;
        @(negedge clk);
        chk("rst_next_gnt1", 32'(gnt1[1]),    32'd1);
        chk("rst_rd_rv_t3",  32'(rvalid1[1]), 32'd0);
        tick;
        req1[1] = 0;

        // Write then read of the same word by requester 0.
        req0[0] = 1; we0[0] = 1; adr0[0] = 32'h44; wdata0[0] = 32'hCAFEF00D;
        @(negedge clk);
        chk("wr_gnt0",  32'(gnt0[0]),   32'd1);
        chk("wr_we",    32'(mem_we[0]), 32'd1);
        chk("wr_wdata", mem_wdata[0],   32'hCAFEF00D);
        tick;
        we0[0] = 0;
        @(negedge clk);
        chk("wrrd_gnt0", 32'(gnt0[0]),   32'd1);
        chk("wrrd_we",   32'(mem_we[0]), 32'd0);
        chk("wrrd_adr",  mem_adr[0],     32'h44);
        sbq[0].push_back('{0, 32'hCAFEF00D, cyc + 1});
        tick;
        req0[0] = 0;
        repeat (3) tick;

        @(negedge clk);
        chk("sbq0_drained", 32'(sbq[0].size()), 32'd0);
        chk("sbq1_drained", 32'(sbq[1].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single unified memory port of the multi-cycle RISC-V core. Requester 0 is the core's DataAdr/WriteData/MemWrite path. Requester 1 is a program loader or debug port. The block grants one access at a time with round-robin fairness. It tracks a fixed-latency synchronous memory read and routes the returned data to the requester that issued it. It sits between the core top level and the instruction/data memory.

## Interface
Parameters:
- WIDTH, 32: address and data width.
- MEM_LATENCY, 1: cycles from the read issue edge to valid mem_rdata. Legal range 1..7.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- req0, req1  in  1: access request. Held high until the matching gnt is seen.
- we0, we1  in  1: 1 = write, 0 = read. Sampled in the grant cycle.
- adr0, adr1  in  WIDTH: byte address. Sampled in the grant cycle.
- wdata0, wdata1  in  WIDTH: write data. Sampled in the grant cycle.
- gnt0, gnt1  out  1: one-cycle pulse. The access is issued to memory in this cycle.
- rvalid0, rvalid1  out  1: one-cycle pulse marking read data valid for that requester.
- rdata0, rdata1  out  WIDTH: read data. Equals mem_rdata while the matching rvalid is high, otherwise 0.
- mem_en  out  1: memory access strobe.
- mem_we  out  1: memory write enable.
- mem_adr  out  WIDTH: memory address.
- mem_wdata  out  WIDTH: memory write data.
- mem_rdata  in  WIDTH: memory read data.

## Operation
- FSM states:
  - IDLE (reset state).
  - RD_WAIT.
- IDLE:
  - If no req is high, all outputs are 0.
  - If any req is high, select a winner and assert its gnt combinationally.
  - In the same cycle, drive mem_en=1 and drive mem_we/mem_adr/mem_wdata from the winner's we/adr/wdata.
- Arbitration:
  - Register `last` holds the index of the last granted requester. Reset value is 1, so requester 0 wins the first tie.
  - If only one req is high, that requester wins.
  - If both are high, the requester not equal to `last` wins.
  - `last` updates on every grant.
- Write grant: the write completes on the grant edge. The FSM stays in IDLE, so a new grant is possible in the next cycle. No rvalid is produced for writes.
- Read grant:
  - Latch the owner index.
  - Load latency counter cnt = MEM_LATENCY-1.
  - Go to RD_WAIT.
- RD_WAIT:
  - No gnt is asserted and mem_en=0; requests are ignored.
  - While cnt≠0, decrement cnt.
  - When cnt==0, assert rvalid[owner] and drive rdata[owner]=mem_rdata, then return to IDLE.
- A req that drops before its gnt is a protocol violation. The arbiter makes no promise on dropped requests; the bench asserts against it.
- Reset mid-operation, including during RD_WAIT:
  - Go to IDLE, clear cnt and owner, set last=1.
  - The in-flight read is discarded and no rvalid is issued.
- Width rules:
  - cnt is 3 bits.
  - adr and wdata pass through unmodified.
  - Byte enables are out of scope; full-word access only.

## Timing
- Reset values: gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_en=0, mem_we=0, mem_adr=0, mem_wdata=0.
- Grant latency is 0 cycles. gnt appears in the same cycle as req when the FSM is in IDLE and the requester wins.
- Read issued in cycle T (gnt high in T):
  - rvalid is high in cycle T+MEM_LATENCY.
  - The next grant is possible at the earliest in cycle T+MEM_LATENCY+1.
- Back-to-back writes from one requester sustain 1 access per cycle when the other requester is idle.
- Under continuous contention, grants alternate strictly 0,1,0,1…
- gnt0 and gnt1 are never high together. rvalid0 and rvalid1 are never high together.

## Structure
- Shared package `arb_pkg`:
  - `arb_state_t` enum {IDLE, RD_WAIT}.
  - Localparam NUM_REQ=2.
  - Localparam MAX_MEM_LATENCY=7.
- Sub-module `rr_select`: combinational 2-way round-robin pick. Inputs: req vector and last. Outputs: one-hot grant and winner index.
- All state lives in the `mem_arbiter` top level.

## Test plan
- Reset → all outputs 0. Release reset, set req0=1, we0=0, adr0=0x40. gnt0 pulses in that cycle with mem_adr=0x40. With MEM_LATENCY=1, rvalid0 is high 1 cycle later with rdata0=mem_rdata=0xDEADBEEF.
- req0 and req1 both high continuously, both writing → gnt sequence 0,1,0,1 on consecutive cycles. mem_wdata alternates between wdata0=0x11 and wdata1=0x22.
- MEM_LATENCY=3, req1 read of adr1=0x100 granted in cycle T, while req0 is held high → no gnt0 in T+1..T+3. rvalid1 is high in T+3. gnt0 is high in T+4.
- Reset asserted in cycle T+1 of a MEM_LATENCY=3 read → no rvalid at T+3. After release, the first contended grant goes to requester 0.
- Write by req0 followed immediately by a read by req0 of the same address (memory model: write then read) → gnt0 in consecutive cycles. rdata0 returns the written value 0xCAFEF00D.
